// File: rtl/cordic.sv
// Iterative rotation-mode CORDIC: one micro-rotation per enabled clock, iteration index driven externally.
// Define CORDIC_GAIN_COMP_EN to scale the outputs by 1/K through a shift-add constant multiply.
module cordic #(
  parameter int FIXED_POINT = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [16:0]            theta_rad,
  input  logic [FIXED_POINT-1:0] data_in_x,
  input  logic [FIXED_POINT-1:0] data_in_y,
  input  logic                   enable_in,
  input  logic                   load_data,
  input  logic [3:0]             Shift_value,
  output logic [FIXED_POINT-1:0] data_out_x,
  output logic [FIXED_POINT-1:0] data_out_y
);

  localparam int ZW = 17;

  // atan(2^-i) in Q2.15, rounded to nearest
  function automatic logic [ZW-1:0] atan_lut(input logic [3:0] idx);
    logic [ZW-1:0] a;
    case (idx)
      4'd0:    a = 17'd25736;
      4'd1:    a = 17'd15193;
      4'd2:    a = 17'd8027;
      4'd3:    a = 17'd4075;
      4'd4:    a = 17'd2045;
      4'd5:    a = 17'd1024;
      4'd6:    a = 17'd512;
      4'd7:    a = 17'd256;
      4'd8:    a = 17'd128;
      4'd9:    a = 17'd64;
      4'd10:   a = 17'd32;
      4'd11:   a = 17'd16;
      4'd12:   a = 17'd8;
      4'd13:   a = 17'd4;
      4'd14:   a = 17'd2;
      default: a = 17'd1;
    endcase
    return a;
  endfunction

  logic signed [FIXED_POINT-1:0] x_q, y_q;
  logic signed [FIXED_POINT-1:0] x_sh, y_sh;
  logic signed [FIXED_POINT-1:0] x_nx, y_nx;
  logic signed [ZW-1:0]          z_q, z_nx, atan_i;

  always_comb begin
    x_sh   = x_q >>> Shift_value;
    y_sh   = y_q >>> Shift_value;
    atan_i = signed'(atan_lut(Shift_value));
    x_nx   = x_q;
    y_nx   = y_q;
    z_nx   = z_q;
    if (z_q[ZW-1]) begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + atan_i;
    end else begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - atan_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else if (enable_in) begin
      if (!load_data) begin
        x_q <= data_in_x;
        y_q <= data_in_y;
        z_q <= theta_rad;
      end else begin
        x_q <= x_nx;
        y_q <= y_nx;
        z_q <= z_nx;
      end
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  // 1/K = 0.607253 in Q0.16
  localparam logic [15:0] INV_K = 16'd39797;

  // Sign-extend, sum shifted copies for each set bit of INV_K, then drop the 16 fraction bits.
  function automatic logic [FIXED_POINT-1:0] gain_comp(input logic signed [FIXED_POINT-1:0] v);
    logic signed [FIXED_POINT+16:0] ext;
    logic signed [FIXED_POINT+16:0] acc;
    ext = {{17{v[FIXED_POINT-1]}}, v};
    acc = '0;
    for (int unsigned b = 0; b < 16; b++) begin
      if (INV_K[b]) acc = acc + (ext <<< b);
    end
    return FIXED_POINT'(acc >>> 16);
  endfunction

  always_comb begin
    data_out_x = gain_comp(x_q);
    data_out_y = gain_comp(y_q);
  end
`else
  always_comb begin
    data_out_x = x_q;
    data_out_y = y_q;
  end
`endif

endmodule

// File: tb/tb_cordic.sv
// Directed bench for cordic: hand-computed register trajectories checked with immediate assertions.
// Expected raw x/y values are scaled through the 1/K output stage when CORDIC_GAIN_COMP_EN is defined.
module tb_cordic;

  logic        clk_tb = 1'b0;
  logic        rst = 1'b0;
  logic [16:0] theta_rad = '0;
  logic [13:0] data_in_x = '0;
  logic [13:0] data_in_y = '0;
  logic        enable_in = 1'b0;
  logic        load_data = 1'b0;
  logic [3:0]  Shift_value = '0;
  logic [13:0] data_out_x, data_out_y;

  int vectors = 0;
  int miscompares = 0;

  cordic #(.FIXED_POINT(14)) dut (
    .clk         (clk_tb),
    .rst         (rst),
    .theta_rad   (theta_rad),
    .data_in_x   (data_in_x),
    .data_in_y   (data_in_y),
    .enable_in   (enable_in),
    .load_data   (load_data),
    .Shift_value (Shift_value),
    .data_out_x  (data_out_x),
    .data_out_y  (data_out_y)
  );

  always #5 clk_tb = ~clk_tb;

  function automatic int exp_out(input int raw);
`ifdef CORDIC_GAIN_COMP_EN
    logic signed [13:0] r;
    longint p;
    r = 14'(raw);
    p = longint'(r) * 39797;
    return int'(p >>> 16);
`else
    return raw;
`endif
  endfunction

  task automatic check(input string tag, input logic [13:0] obs, input int expv);
    logic [13:0] e;
    e = 14'(expv);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(e));
    end
  endtask

  task automatic check_xy(input string tag, input int ex, input int ey);
    check({tag, ".x"}, data_out_x, exp_out(ex));
    check({tag, ".y"}, data_out_y, exp_out(ey));
  endtask

  task automatic cyc();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic do_load(input int x, input int y, input int t);
    enable_in = 1'b1;
    load_data = 1'b0;
    data_in_x = 14'(x);
    data_in_y = 14'(y);
    theta_rad = 17'(t);
    cyc();
  endtask

  task automatic do_iter(input int i);
    enable_in   = 1'b1;
    load_data   = 1'b1;
    Shift_value = 4'(i);
    cyc();
  endtask

  task automatic run_iters(input int first, input int last);
    for (int i = first; i <= last; i++) do_iter(i);
  endtask

  initial begin
    // asynchronous reset, no clock edge needed
    #1 rst = 1'b1;
    #1 check_xy("reset_async", 0, 0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    check_xy("after_release", 0, 0);

    // pi/3 rotation
    do_load(2048, 0, 34315);
    check_xy("pi3_load", 2048, 0);
    run_iters(0, 4);
    check_xy("pi3_iter4", 1630, 2950);
    run_iters(5, 13);
    check_xy("pi3_final", 1686, 2921);

    // zero angle
    do_load(2048, 0, 0);
    run_iters(0, 13);
    check_xy("zero_final", 3373, 0);

    // negative angle
    do_load(2048, 0, -34315);
    run_iters(0, 13);
    check_xy("neg_final", 1687, -2921);

    // enable hold between iterations 6 and 7; mode/index inputs must be ignored
    do_load(2048, 0, 34315);
    run_iters(0, 6);
    check_xy("hold_iter6", 1677, 2926);
    enable_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      load_data   = k[0];
      Shift_value = 4'(k + 1);
      data_in_x   = 14'(100 + k);
      cyc();
      check_xy("hold_gap", 1677, 2926);
    end
    run_iters(7, 13);
    check_xy("hold_final", 1686, 2921);

    // reset mid-sequence, then reload and rerun
    do_load(2048, 0, 34315);
    run_iters(0, 4);
    check_xy("mid_iter4", 1630, 2950);
    rst = 1'b1;
    #1 check_xy("mid_reset_async", 0, 0);
    do_iter(5);
    check_xy("mid_reset_held", 0, 0);
    rst = 1'b0;
    enable_in = 1'b0;
    cyc();
    check_xy("mid_released", 0, 0);
    do_load(2048, 0, 34315);
    run_iters(0, 13);
    check_xy("mid_rerun", 1686, 2921);

    // indices 15/14 use the LUT; repeated index applied literally
    do_load(2048, 0, 0);
    do_iter(15);
    check_xy("idx15", 2048, 0);
    do_iter(0);
    check_xy("idx15_then0", 2048, -2048);
    do_iter(14);
    check_xy("idx14", 2049, -2048);
    do_iter(0);
    check_xy("idx0_repeat", 4097, 1);

    // modular wrap, no saturation
    do_load(8191, 8191, 0);
    do_iter(0);
    check_xy("wrap", 0, -2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
